// File: rtl/axi_wr_arbiter_pkg.sv
// Shared types and AXI constants for the two-requester write-channel arbiter.
package axi_wr_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2,
    RESP = 2'd3
  } wr_arb_state_e;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

  localparam logic [1:0] AXI_BURST_FIXED = 2'b00;
  localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
  localparam logic [1:0] AXI_BURST_WRAP  = 2'b10;

endpackage

// File: rtl/axi_wr_arbiter_if.sv
// Write-channel bundle: two upstream requester ports (s_*) and one downstream master port (m_*).
interface axi_wr_arbiter_if #(
  parameter int unsigned AXI_ADDR_WIDTH = 32,
  parameter int unsigned AXI_DATA_WIDTH = 64,
  parameter int unsigned AXI_ID_WIDTH   = 4
);
  logic [1:0][AXI_ADDR_WIDTH-1:0]   s_awaddr;
  logic [1:0][7:0]                  s_awlen;
  logic [1:0][2:0]                  s_awsize;
  logic [1:0][1:0]                  s_awburst;
  logic [1:0][AXI_ID_WIDTH-1:0]     s_awid;
  logic [1:0]                       s_awvalid;
  logic [1:0]                       s_awready;
  logic [1:0][AXI_DATA_WIDTH-1:0]   s_wdata;
  logic [1:0][AXI_DATA_WIDTH/8-1:0] s_wstrb;
  logic [1:0]                       s_wlast;
  logic [1:0]                       s_wvalid;
  logic [1:0]                       s_wready;
  logic [1:0][1:0]                  s_bresp;
  logic [1:0][AXI_ID_WIDTH-1:0]     s_bid;
  logic [1:0]                       s_bvalid;
  logic [1:0]                       s_bready;

  logic [AXI_ADDR_WIDTH-1:0]        m_awaddr;
  logic [7:0]                       m_awlen;
  logic [2:0]                       m_awsize;
  logic [1:0]                       m_awburst;
  logic [AXI_ID_WIDTH-1:0]          m_awid;
  logic                             m_awvalid;
  logic                             m_awready;
  logic [AXI_DATA_WIDTH-1:0]        m_wdata;
  logic [AXI_DATA_WIDTH/8-1:0]      m_wstrb;
  logic                             m_wlast;
  logic                             m_wvalid;
  logic                             m_wready;
  logic [1:0]                       m_bresp;
  logic [AXI_ID_WIDTH-1:0]          m_bid;
  logic                             m_bvalid;
  logic                             m_bready;

  // Arbiter view: slave to the requesters, master to the downstream port.
  modport slave (
    input  s_awaddr, s_awlen, s_awsize, s_awburst, s_awid, s_awvalid,
    output s_awready,
    input  s_wdata, s_wstrb, s_wlast, s_wvalid,
    output s_wready,
    output s_bresp, s_bid, s_bvalid,
    input  s_bready,
    output m_awaddr, m_awlen, m_awsize, m_awburst, m_awid, m_awvalid,
    input  m_awready,
    output m_wdata, m_wstrb, m_wlast, m_wvalid,
    input  m_wready,
    input  m_bresp, m_bid, m_bvalid,
    output m_bready
  );

  // Environment view: requesters and downstream slave.
  modport master (
    output s_awaddr, s_awlen, s_awsize, s_awburst, s_awid, s_awvalid,
    input  s_awready,
    output s_wdata, s_wstrb, s_wlast, s_wvalid,
    input  s_wready,
    input  s_bresp, s_bid, s_bvalid,
    output s_bready,
    input  m_awaddr, m_awlen, m_awsize, m_awburst, m_awid, m_awvalid,
    output m_awready,
    input  m_wdata, m_wstrb, m_wlast, m_wvalid,
    output m_wready,
    output m_bresp, m_bid, m_bvalid,
    input  m_bready
  );
endinterface

// File: rtl/axi_wr_arbiter_rr_arbiter_2.sv
// Combinational two-way round-robin picker: requester at ptr has priority.
module rr_arbiter_2 (
  input  logic [1:0] req,
  input  logic       ptr,
  output logic       gnt,
  output logic       any_req
);
  always_comb begin
    any_req = |req;
    if (req[ptr])       gnt = ptr;
    else if (req[~ptr]) gnt = ~ptr;
    else                gnt = ptr;
  end
endmodule

// File: rtl/axi_wr_arbiter.sv
// Shares one AXI write path between two requesters, one whole transaction at a time,
// with a beat counter generating downstream wlast and sticky per-requester wlast mismatch flags.
module axi_wr_arbiter
  import axi_wr_arbiter_pkg::*;
#(
  parameter int unsigned AXI_ADDR_WIDTH = 32,
  parameter int unsigned AXI_DATA_WIDTH = 64,
  parameter int unsigned AXI_ID_WIDTH   = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  axi_wr_arbiter_if.slave     bus,
  output logic [1:0]          wlast_err
);

  wr_arb_state_e state;
  logic          gnt;
  logic          rr_ptr;
  logic [7:0]    beat_cnt;
  logic [7:0]    len_q;

  logic          pick;
  logic          any_req;
  logic          in_addr, in_data, in_resp;
  logic          w_hs;

  logic [AXI_ADDR_WIDTH-1:0]   awaddr_sel;
  logic [AXI_ID_WIDTH-1:0]     awid_sel;
  logic [AXI_DATA_WIDTH-1:0]   wdata_sel;
  logic [AXI_DATA_WIDTH/8-1:0] wstrb_sel;

  rr_arbiter_2 u_rr (
    .req     (bus.s_awvalid),
    .ptr     (rr_ptr),
    .gnt     (pick),
    .any_req (any_req)
  );

  // All muxes hang off the registered grant; outside their phase every output is forced to zero.
  always_comb begin
    in_addr    = (state == ADDR);
    in_data    = (state == DATA);
    in_resp    = (state == RESP);
    awaddr_sel = bus.s_awaddr[gnt];
    awid_sel   = bus.s_awid[gnt];
    wdata_sel  = bus.s_wdata[gnt];
    wstrb_sel  = bus.s_wstrb[gnt];

    bus.m_awvalid = in_addr & bus.s_awvalid[gnt];
    bus.m_awaddr  = in_addr ? awaddr_sel : '0;
    bus.m_awlen   = in_addr ? bus.s_awlen[gnt] : '0;
    bus.m_awsize  = in_addr ? bus.s_awsize[gnt] : '0;
    bus.m_awburst = in_addr ? bus.s_awburst[gnt] : '0;
    bus.m_awid    = in_addr ? awid_sel : '0;

    bus.m_wvalid  = in_data & bus.s_wvalid[gnt];
    bus.m_wdata   = in_data ? wdata_sel : '0;
    bus.m_wstrb   = in_data ? wstrb_sel : '0;
    bus.m_wlast   = in_data & (beat_cnt == len_q);
    w_hs          = bus.m_wvalid & bus.m_wready;

    bus.m_bready  = in_resp & bus.s_bready[gnt];

    bus.s_awready = '0;
    bus.s_wready  = '0;
    bus.s_bvalid  = '0;
    bus.s_bresp   = '0;
    bus.s_bid     = '0;
    if (in_addr) bus.s_awready[gnt] = bus.m_awready;
    if (in_data) bus.s_wready[gnt]  = bus.m_wready;
    if (in_resp) begin
      bus.s_bvalid[gnt] = bus.m_bvalid;
      bus.s_bresp[gnt]  = bus.m_bresp;
      bus.s_bid[gnt]    = bus.m_bid;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      gnt       <= 1'b0;
      rr_ptr    <= 1'b0;
      beat_cnt  <= '0;
      len_q     <= '0;
      wlast_err <= '0;
    end else begin
      case (state)
        IDLE: if (any_req) begin
          gnt   <= pick;
          len_q <= bus.s_awlen[pick];
          state <= ADDR;
        end
        ADDR: if (bus.m_awvalid && bus.m_awready) begin
          beat_cnt <= '0;
          state    <= DATA;
        end
        DATA: if (w_hs) begin
          beat_cnt <= beat_cnt + 8'd1;
          if (bus.s_wlast[gnt] != bus.m_wlast) wlast_err[gnt] <= 1'b1;
          if (bus.m_wlast) state <= RESP;
        end
        RESP: if (bus.m_bvalid && bus.m_bready) begin
          rr_ptr <= ~gnt;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
